// File: rtl/cpu_pkg.sv
// Shared datapath types: bus/MAR select encodings,
// ALU opcodes and CCR bit positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    B1_PC   = 2'd0,
    B1_REG  = 2'd1,
    B1_SP   = 2'd2,
    B1_ZERO = 2'd3
  } bus1_sel_e;

  typedef enum logic [1:0] {
    B2_ALU  = 2'd0,
    B2_BUS1 = 2'd1,
    B2_MEM  = 2'd2,
    B2_ZERO = 2'd3
  } bus2_sel_e;

  typedef enum logic {
    MAR_BUS2 = 1'b0,
    MAR_SP   = 1'b1
  } mar_sel_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_NOT    = 4'd5;
  localparam logic [3:0] ALU_SHL    = 4'd6;
  localparam logic [3:0] ALU_SHR    = 4'd7;
  localparam logic [3:0] ALU_PASS_B = 4'd8;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

endpackage

// File: rtl/datapath_param_if.sv
// Memory-side bus of the datapath: address and
// write data out, read data in.
interface datapath_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_memory;
  logic [DATA_W-1:0] from_memory;

  modport master (
    output address,
    output to_memory,
    input  from_memory
  );

  modport slave (
    input  address,
    input  to_memory,
    output from_memory
  );
endinterface

// File: rtl/datapath_param_alu.sv
// Combinational ALU; flags returned as {N,Z,V,C},
// with V and C taken at the top data bit.
module alu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);
  localparam int M = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            v;
  logic            c;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = a;
    v      = 1'b0;
    c      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[M:0];
        c      = sum[DATA_W];
        v      = (a[M] == b[M]) && (result[M] != a[M]);
      end
      ALU_SUB: begin
        result = diff[M:0];
        c      = diff[DATA_W];
        v      = (a[M] != b[M]) && (result[M] != a[M]);
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOT:    result = ~a;
      ALU_SHL: begin
        result = {a[M-1:0], 1'b0};
        c      = a[M];
      end
      ALU_SHR: begin
        result = {1'b0, a[M:1]};
        c      = a[0];
      end
      ALU_PASS_B: result = b;
      default:    result = a;
    endcase
    flags[CCR_N] = result[M];
    flags[CCR_Z] = (result == '0);
    flags[CCR_V] = v;
    flags[CCR_C] = c;
  end
endmodule

// File: rtl/datapath_param.sv
// Parametrised CPU datapath: register file, PC,
// MAR, IR, SP with sticky fault, masked CCR.
module datapath_param
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ir_load,
  output logic [DATA_W-1:0]           ir,
  input  logic                        mar_load,
  input  logic                        mar_sel,
  input  logic                        pc_load,
  input  logic                        pc_inc,
  input  logic                        reg_load,
  input  logic [$clog2(NUM_REGS)-1:0] reg_wsel,
  input  logic [$clog2(NUM_REGS)-1:0] reg_rsel,
  input  logic [$clog2(NUM_REGS)-1:0] alu_b_sel,
  input  logic [1:0]                  bus1_sel,
  input  logic [1:0]                  bus2_sel,
  input  logic [3:0]                  alu_sel,
  input  logic [3:0]                  ccr_load_mask,
  output logic [3:0]                  ccr_result,
  input  logic                        sp_push,
  input  logic                        sp_pop,
  input  logic                        stack_fault_clr,
  output logic                        stack_fault,
  datapath_param_if.master            mem
);
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [3:0]        ccr_q, ccr_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0] bus1, bus2;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;
  logic              fault_set;
  bus1_sel_e         b1;
  bus2_sel_e         b2;

  assign b1 = bus1_sel_e'(bus1_sel);
  assign b2 = bus2_sel_e'(bus2_sel);

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .a      (bus1),
    .b      (regs_q[alu_b_sel]),
    .op     (alu_sel),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    bus1 = '0;
    unique case (b1)
      B1_PC:   bus1 = DATA_W'(pc_q);
      B1_REG:  bus1 = regs_q[reg_rsel];
      B1_SP:   bus1 = DATA_W'(sp_q);
      B1_ZERO: bus1 = '0;
    endcase
    bus2 = '0;
    unique case (b2)
      B2_ALU:  bus2 = alu_res;
      B2_BUS1: bus2 = bus1;
      B2_MEM:  bus2 = mem.from_memory;
      B2_ZERO: bus2 = '0;
    endcase
  end

  always_comb begin
    ir_d  = ir_load ? bus2 : ir_q;
    pc_d  = pc_q;
    if (pc_load)     pc_d = ADDR_W'(bus2);
    else if (pc_inc) pc_d = pc_q + 1'b1;
    mar_d = mar_q;
    if (mar_load)
      mar_d = (mar_sel_e'(mar_sel) == MAR_SP)
            ? sp_q : ADDR_W'(bus2);
    regs_d = regs_q;
    if (reg_load) regs_d[reg_wsel] = bus2;
    for (int i = 0; i < 4; i++)
      ccr_d[i] = ccr_load_mask[i] ? alu_flags[i] : ccr_q[i];
  end

  // Boundary moves are refused and latch the fault instead.
  always_comb begin
    sp_d      = sp_q;
    fault_set = 1'b0;
    if (sp_push && !sp_pop) begin
      if (sp_q == '0) fault_set = 1'b1;
      else            sp_d      = sp_q - 1'b1;
    end else if (sp_pop && !sp_push) begin
      if (sp_q == SP_INIT) fault_set = 1'b1;
      else                 sp_d      = sp_q + 1'b1;
    end
    fault_d = fault_set | (fault_q & ~stack_fault_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      mar_q   <= '0;
      pc_q    <= '0;
      sp_q    <= SP_INIT;
      ccr_q   <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else begin
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ccr_q   <= ccr_d;
      fault_q <= fault_d;
      regs_q  <= regs_d;
    end
  end

  assign ir            = ir_q;
  assign ccr_result    = ccr_q;
  assign stack_fault   = fault_q;
  assign mem.address   = mar_q;
  assign mem.to_memory = bus1;
endmodule

// File: tb/tb_datapath_param.sv
// Directed bench: default 8-bit datapath plus a
// 16/12-bit, 8-register instance.
module tb_datapath_param;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       ir_load, mar_load, mar_sel;
  logic       pc_load, pc_inc, reg_load;
  logic [1:0] reg_wsel, reg_rsel, alu_b_sel;
  logic [1:0] bus1_sel, bus2_sel;
  logic [3:0] alu_sel, ccr_load_mask, ccr_result;
  logic       sp_push, sp_pop, stack_fault_clr;
  logic       stack_fault;
  logic [7:0] ir;

  datapath_param_if #(.DATA_W(8), .ADDR_W(8)) mem_a ();

  datapath_param u_dut (
    .clk(clk), .reset(reset),
    .ir_load(ir_load), .ir(ir),
    .mar_load(mar_load), .mar_sel(mar_sel),
    .pc_load(pc_load), .pc_inc(pc_inc),
    .reg_load(reg_load), .reg_wsel(reg_wsel),
    .reg_rsel(reg_rsel), .alu_b_sel(alu_b_sel),
    .bus1_sel(bus1_sel), .bus2_sel(bus2_sel),
    .alu_sel(alu_sel),
    .ccr_load_mask(ccr_load_mask),
    .ccr_result(ccr_result),
    .sp_push(sp_push), .sp_pop(sp_pop),
    .stack_fault_clr(stack_fault_clr),
    .stack_fault(stack_fault),
    .mem(mem_a.master)
  );

  logic        mar_load_b, reg_load_b;
  logic [2:0]  reg_wsel_b, reg_rsel_b;
  logic [1:0]  bus1_sel_b, bus2_sel_b;
  logic [15:0] ir_b;
  logic [3:0]  ccr_b;
  logic        fault_b;

  datapath_param_if #(.DATA_W(16), .ADDR_W(12)) mem_b ();

  datapath_param #(
    .DATA_W(16), .ADDR_W(12), .NUM_REGS(8)
  ) u_dut_w (
    .clk(clk), .reset(reset),
    .ir_load(1'b0), .ir(ir_b),
    .mar_load(mar_load_b), .mar_sel(1'b0),
    .pc_load(1'b0), .pc_inc(1'b0),
    .reg_load(reg_load_b), .reg_wsel(reg_wsel_b),
    .reg_rsel(reg_rsel_b), .alu_b_sel(3'd0),
    .bus1_sel(bus1_sel_b), .bus2_sel(bus2_sel_b),
    .alu_sel(4'd0), .ccr_load_mask(4'd0),
    .ccr_result(ccr_b),
    .sp_push(1'b0), .sp_pop(1'b0),
    .stack_fault_clr(1'b0),
    .stack_fault(fault_b),
    .mem(mem_b.master)
  );

  task automatic idle;
    ir_load = 0; mar_load = 0; mar_sel = 0;
    pc_load = 0; pc_inc = 0; reg_load = 0;
    reg_wsel = 0; reg_rsel = 0; alu_b_sel = 0;
    bus1_sel = B1_PC; bus2_sel = B2_ALU;
    alu_sel = ALU_ADD; ccr_load_mask = 0;
    sp_push = 0; sp_pop = 0; stack_fault_clr = 0;
    mem_a.from_memory = 8'h00;
    mar_load_b = 0; reg_load_b = 0;
    reg_wsel_b = 0; reg_rsel_b = 0;
    bus1_sel_b = B1_PC; bus2_sel_b = B2_ALU;
    mem_b.from_memory = 16'h0000;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    idle();
    mem_a.from_memory = 8'h55;
    bus2_sel = B2_MEM; ir_load = 1; mar_load = 1;
    tick();
    n_cmp++;
    if (ir !== 8'h55) begin
      n_bad++; $display("FAIL ir_load: got %h want 55", ir);
    end
    n_cmp++;
    if (mem_a.address !== 8'h55) begin
      n_bad++;
      $display("FAIL mar_load: got %h want 55", mem_a.address);
    end
    mem_a.from_memory = 8'h66;
    #2 reset = 0;
    #1;
    n_cmp++;
    if (ir !== 8'h00 || mem_a.address !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset: ir %h addr %h want 00 00",
               ir, mem_a.address);
    end
    n_cmp++;
    if (ccr_result !== 4'h0 || stack_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: ccr %b flt %b want 0000 0",
               ccr_result, stack_fault);
    end
    n_cmp++;
    if (mem_a.to_memory !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_pc_bus: got %h want 00",
               mem_a.to_memory);
    end
    tick();
    bus1_sel = B1_SP;
    #1;
    n_cmp++;
    if (ir !== 8'h00 || mem_a.to_memory !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_hold: ir %h sp %h want 00 ff",
               ir, mem_a.to_memory);
    end
    idle();
    reset = 1;
    tick();
  endtask

  task automatic test_load_add;
    idle();
    bus2_sel = B2_MEM; reg_load = 1;
    mem_a.from_memory = 8'h7F; reg_wsel = 0;
    tick();
    mem_a.from_memory = 8'h01; reg_wsel = 1;
    tick();
    idle();
    bus1_sel = B1_REG; reg_rsel = 0; alu_b_sel = 1;
    alu_sel = ALU_ADD; bus2_sel = B2_ALU;
    reg_load = 1; reg_wsel = 2; ccr_load_mask = 4'b1111;
    #1;
    n_cmp++;
    if (mem_a.to_memory !== 8'h7F) begin
      n_bad++;
      $display("FAIL bus1_r0: got %h want 7f", mem_a.to_memory);
    end
    tick();
    idle();
    bus1_sel = B1_REG; reg_rsel = 2;
    #1;
    n_cmp++;
    if (mem_a.to_memory !== 8'h80) begin
      n_bad++;
      $display("FAIL add_r2: got %h want 80", mem_a.to_memory);
    end
    n_cmp++;
    if (ccr_result !== 4'b1010) begin
      n_bad++;
      $display("FAIL ccr_full: got %b want 1010", ccr_result);
    end
    alu_b_sel = 2; alu_sel = ALU_ADD;
    ccr_load_mask = 4'b0001;
    tick();
    n_cmp++;
    if (ccr_result !== 4'b1011) begin
      n_bad++;
      $display("FAIL ccr_mask_c: got %b want 1011", ccr_result);
    end
    idle();
    bus1_sel = B1_REG; reg_rsel = 0; alu_b_sel = 1;
    alu_sel = ALU_SUB; ccr_load_mask = 4'b1111;
    tick();
    n_cmp++;
    if (ccr_result !== 4'b0000) begin
      n_bad++;
      $display("FAIL ccr_sub: got %b want 0000", ccr_result);
    end
  endtask

  task automatic test_pc;
    idle();
    mem_a.from_memory = 8'hFF; bus2_sel = B2_MEM;
    pc_load = 1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (mem_a.to_memory !== 8'hFF) begin
      n_bad++;
      $display("FAIL pc_load: got %h want ff", mem_a.to_memory);
    end
    pc_inc = 1;
    tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'h00) begin
      n_bad++;
      $display("FAIL pc_wrap: got %h want 00", mem_a.to_memory);
    end
    tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'h01) begin
      n_bad++;
      $display("FAIL pc_inc: got %h want 01", mem_a.to_memory);
    end
    mem_a.from_memory = 8'h42; bus2_sel = B2_MEM;
    pc_load = 1; pc_inc = 1;
    tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'h42) begin
      n_bad++;
      $display("FAIL pc_prio: got %h want 42", mem_a.to_memory);
    end
  endtask

  task automatic test_stack;
    idle();
    bus1_sel = B1_SP; sp_push = 1;
    repeat (3) tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'hFC) begin
      n_bad++;
      $display("FAIL push3: got %h want fc", mem_a.to_memory);
    end
    mar_load = 1; mar_sel = MAR_SP;
    tick();
    mar_load = 0;
    n_cmp++;
    if (mem_a.address !== 8'hFC || mem_a.to_memory !== 8'hFB)
    begin
      n_bad++;
      $display("FAIL mar_sp: mar %h sp %h want fc fb",
               mem_a.address, mem_a.to_memory);
    end
    sp_pop = 1;
    tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'hFB || stack_fault !== 1'b0)
    begin
      n_bad++;
      $display("FAIL push_pop: sp %h flt %b want fb 0",
               mem_a.to_memory, stack_fault);
    end
  endtask

  task automatic test_stack_fault;
    idle();
    bus1_sel = B1_SP; sp_pop = 1;
    repeat (4) tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'hFF || stack_fault !== 1'b0)
    begin
      n_bad++;
      $display("FAIL pop_to_top: sp %h flt %b want ff 0",
               mem_a.to_memory, stack_fault);
    end
    tick();
    sp_pop = 0;
    n_cmp++;
    if (mem_a.to_memory !== 8'hFF || stack_fault !== 1'b1)
    begin
      n_bad++;
      $display("FAIL pop_underflow: sp %h flt %b want ff 1",
               mem_a.to_memory, stack_fault);
    end
    tick();
    n_cmp++;
    if (stack_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_sticky: got %b want 1", stack_fault);
    end
    stack_fault_clr = 1;
    tick();
    stack_fault_clr = 0;
    n_cmp++;
    if (stack_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clr: got %b want 0", stack_fault);
    end
    sp_push = 1;
    repeat (255) tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'h00 || stack_fault !== 1'b0)
    begin
      n_bad++;
      $display("FAIL push_to_zero: sp %h flt %b want 00 0",
               mem_a.to_memory, stack_fault);
    end
    tick();
    n_cmp++;
    if (mem_a.to_memory !== 8'h00 || stack_fault !== 1'b1)
    begin
      n_bad++;
      $display("FAIL push_overflow: sp %h flt %b want 00 1",
               mem_a.to_memory, stack_fault);
    end
    stack_fault_clr = 1;
    tick();
    n_cmp++;
    if (stack_fault !== 1'b1) begin
      n_bad++;
      $display("FAIL set_beats_clr: got %b want 1", stack_fault);
    end
    sp_push = 0;
    tick();
    stack_fault_clr = 0;
    n_cmp++;
    if (stack_fault !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_clr2: got %b want 0", stack_fault);
    end
  endtask

  task automatic test_width;
    idle();
    mem_b.from_memory = 16'hABCD; bus2_sel_b = B2_MEM;
    mar_load_b = 1;
    tick();
    mar_load_b = 0;
    n_cmp++;
    if (mem_b.address !== 12'hBCD) begin
      n_bad++;
      $display("FAIL mar_trunc: got %h want bcd", mem_b.address);
    end
    mem_b.from_memory = 16'h1111;
    reg_load_b = 1; reg_wsel_b = 7;
    tick();
    mem_b.from_memory = 16'h2222;
    bus1_sel_b = B1_REG; reg_rsel_b = 7;
    #1;
    n_cmp++;
    if (mem_b.to_memory !== 16'h1111) begin
      n_bad++;
      $display("FAIL r7_old: got %h want 1111", mem_b.to_memory);
    end
    tick();
    reg_load_b = 0;
    n_cmp++;
    if (mem_b.to_memory !== 16'h2222) begin
      n_bad++;
      $display("FAIL r7_new: got %h want 2222", mem_b.to_memory);
    end
    bus1_sel_b = B1_SP;
    #1;
    n_cmp++;
    if (mem_b.to_memory !== 16'h0FFF) begin
      n_bad++;
      $display("FAIL sp_zext: got %h want 0fff", mem_b.to_memory);
    end
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    test_reset();
    test_load_add();
    test_pc();
    test_stack();
    test_stack_fault();
    test_width();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath_param.md
# datapath_param

Parametrised second-generation CPU datapath for the 8-bit microcontroller family. It widens the fixed A/B accumulator pair into a general register file and adds configurable data and address widths, a hardware stack pointer with sticky fault detection, a selectable MAR source, and per-flag CCR update. It sits between the control FSM, which drives every load/select strobe, and program/data memory, which drives `from_memory` and receives `address` and `to_memory`.

## Interface
Parameters:
- `DATA_W`, 8: datapath, register, IR and memory data width (≥4).
- `ADDR_W`, 8: PC, MAR, SP and address width.
- `NUM_REGS`, 4: general registers R0..R(NUM_REGS-1), power of two, ≥2.
- `SP_INIT`, all ones (ADDR_W bits): SP reset value and empty-stack value.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ir_load` in 1: IR ← BUS2.
- `ir` out DATA_W: IR contents.
- `mar_load` in 1: load MAR.
- `mar_sel` in 1: MAR source, 0 = BUS2, 1 = SP.
- `address` out ADDR_W: MAR contents.
- `pc_load` in 1: PC ← BUS2.
- `pc_inc` in 1: PC ← PC+1.
- `reg_load` in 1: R[reg_wsel] ← BUS2.
- `reg_wsel` in log2(NUM_REGS): write index.
- `reg_rsel` in log2(NUM_REGS): BUS1 register read index.
- `alu_b_sel` in log2(NUM_REGS): ALU B operand index.
- `bus1_sel` in 2: 0 PC, 1 R[reg_rsel], 2 SP, 3 zero.
- `bus2_sel` in 2: 0 ALU result, 1 BUS1, 2 `from_memory`, 3 zero.
- `alu_sel` in 4: ALU operation code.
- `ccr_load_mask` in 4: per-flag load enables for N, Z, V, C (bit 3..0).
- `ccr_result` out 4: CCR (N, Z, V, C).
- `sp_push` in 1: SP decrement.
- `sp_pop` in 1: SP increment.
- `stack_fault_clr` in 1: clear sticky fault.
- `stack_fault` out 1: sticky overflow/underflow flag.
- `from_memory` in DATA_W: memory read data.
- `to_memory` out DATA_W: BUS1, combinational.

## Operation
- **Width conversion:** PC and SP onto BUS1 are zero-extended or truncated to DATA_W. BUS2 into PC or MAR is zero-extended or truncated to ADDR_W.
- **PC:** `pc_load` has priority over `pc_inc`. Increment wraps modulo 2^ADDR_W.
- **Register file:**
  - Two combinational read ports: `reg_rsel` feeds BUS1, `alu_b_sel` feeds ALU B.
  - One synchronous write port.
  - A read in the same cycle as a write to the same register returns the old value; there is no bypass.
- **ALU:** A = BUS1, B = R[alu_b_sel]. It produces a result and NZVC.
- **CCR:** each CCR bit updates from ALU NZVC only when its mask bit is set; the other bits hold.
- **Push** (push only): SP ← SP−1. If SP == 0, SP holds and fault sets.
- **Pop** (pop only): SP ← SP+1. If SP == SP_INIT, SP holds and fault sets.
- **Push and pop together:** SP unchanged, no fault.
- **Stack fault flag:**
  - Sticky until `stack_fault_clr`.
  - If set and clear occur in the same cycle, set wins.
- **MAR with `mar_sel`=1:** MAR samples SP's pre-update value in the same cycle as a push or pop.
- **Out-of-range select codes:** none exist; all encodings are defined above.

## Timing
- **Reset values:**
  - IR, MAR, PC, all R, CCR = 0; `stack_fault` = 0; SP = SP_INIT.
  - Consequently `ir`, `address`, `ccr_result` = 0 and `stack_fault` = 0 while reset is low.
  - `to_memory` = 0 during reset when `bus1_sel` = 0.
- **Reset behaviour:** reset asserts asynchronously mid-operation and aborts any load. Deassertion is synchronised externally.
- **Registered outputs:** all state updates on the rising `clk` edge. Loaded values appear on outputs one cycle after the strobe.
- **Combinational paths:** `to_memory`, BUS1, BUS2 and the ALU are combinational from the current registers and selects, with zero latency.
- **Same-edge sampling:** a value on BUS2 and its destination's load strobe are sampled on the same edge. Multiple destinations may load the same BUS2 value on one edge.

## Structure
- **Package `cpu_pkg`:**
  - BUS1/BUS2 select enums.
  - MAR source enum.
  - ALU opcode constants, shared with the control FSM.
  - CCR bit-index constants (N=3, Z=2, V=1, C=0).
- **Sub-module `alu_param`:** combinational, parametrised on DATA_W. V and C are computed at bit DATA_W−1.
- **Register file:** an unpacked array inside `datapath_param`; no separate module.

## Test plan
- **Reset state:** assert reset mid-run → `address`=0, `ir`=0, `ccr_result`=0, `stack_fault`=0, SP=SP_INIT (0xFF at defaults).
- **Load, add, flags:**
  - Stimulus: `from_memory`=0x7F into R0; `from_memory`=0x01 into R1; ADD with BUS1=R0, B=R1, mask=4'b1111, result to R2.
  - Response: R2=0x80, `ccr_result`=4'b1010.
  - Repeat with mask=4'b0001: only C updates.
- **PC behaviour:**
  - PC=0xFF with `pc_inc` → 0x00.
  - `pc_load` and `pc_inc` together with BUS2=0x42 → PC=0x42.
- **Stack:**
  - Push three times from reset → SP=0xFC.
  - `mar_sel`=1 with push → MAR=0xFC and SP=0xFB.
  - Push and pop together → SP unchanged.
- **Stack faults:**
  - Pop at SP=0xFF → SP stays 0xFF, `stack_fault`=1 until cleared.
  - Push at SP=0x00 → fault.
  - Fault set and clear in the same cycle → fault remains 1.
- **Width parameters:** DATA_W=16, ADDR_W=12, NUM_REGS=8. Load 0xABCD into MAR via BUS2 → `address`=0xBCD. Write R7, read it the same cycle → old value, new value the next cycle.
